at_byte_collector: RTL and testbench

- Receive end of the AT output interface: consumes the serial `out_valid`/`out_data` byte stream and reassembles it into 128-bit words, the same width as the AT `A` input.
- Completed words are buffered in a 2-entry FIFO and offered downstream on a valid/ready handshake.
- Gap timeout and overflow detection flag malformed or unconsumed result streams.
- Used in the bench and at SoC level wherever AT results must be compared or forwarded as whole words.

---
 rtl/at_byte_collector.sv | 136 +++++++++++++
 tb/tb_at_byte_collector.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/at_byte_collector.sv
// Reassembles the serial AT result byte stream into whole words (MSB-first) and
// offers them downstream via a 2-entry first-fall-through FIFO.
module at_byte_collector #(
    parameter int NUM_BYTES = 16,
    parameter int DATA_W    = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          word_ready,
    input  logic                          err_clr,
    output logic                          word_valid,
    output logic [NUM_BYTES*DATA_W-1:0]   word_data,
    output logic [1:0]                    fill_cnt,
    output logic                          overflow,
    output logic                          frag_err
);
    localparam int W     = NUM_BYTES * DATA_W;
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_COLLECT = 1'b1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);
    localparam logic [7:0]       GAP_LAST = 8'(TIMEOUT - 1);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       gap_q, gap_d;
    logic [W-1:0]     asm_q, asm_d;
    logic [W-1:0]     byte_word;
    logic             push, frag_set;

    logic [W-1:0]     mem_q [2];
    logic [W-1:0]     hold_q;
    logic             rd_q, wr_q;
    logic [1:0]       cnt_q, cnt_d;
    logic             pop, accept, ovf_set;
    logic             ovf_q, frag_q;

    // Shifting in at the bottom lands byte 0 in the top lane once the word completes.
    assign byte_word = {asm_q[W-DATA_W-1:0], in_data};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        asm_d    = asm_q;
        push     = 1'b0;
        frag_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    asm_d   = byte_word;
                    idx_d   = IDX_W'(1);
                    gap_d   = 8'd0;
                    state_d = S_COLLECT;
                end
            end
            default: begin
                if (in_valid) begin
                    asm_d = byte_word;
                    gap_d = 8'd0;
                    if (idx_q == IDX_LAST) begin
                        push    = 1'b1;
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (gap_q == GAP_LAST) begin
                    frag_set = 1'b1;
                    idx_d    = '0;
                    gap_d    = 8'd0;
                    state_d  = S_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
        endcase
    end

    assign pop     = (cnt_q != 2'd0) && word_ready;
    assign accept  = push && ((cnt_q != 2'd2) || pop);
    assign ovf_set = push && (cnt_q == 2'd2) && !pop;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !pop)      cnt_d = cnt_q + 2'd1;
        else if (!accept && pop) cnt_d = cnt_q - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            gap_q    <= 8'd0;
            asm_q    <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            hold_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            cnt_q    <= 2'd0;
            ovf_q    <= 1'b0;
            frag_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                mem_q[wr_q] <= byte_word;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                hold_q <= mem_q[rd_q];
                rd_q   <= ~rd_q;
            end
            // Set beats a same-cycle clear.
            ovf_q  <= ovf_set  | (ovf_q  & ~err_clr);
            frag_q <= frag_set | (frag_q & ~err_clr);
        end
    end

    // When drained, keep showing the last popped word instead of a stale slot.
    assign word_data  = (cnt_q == 2'd0) ? hold_q : mem_q[rd_q];
    assign word_valid = (cnt_q != 2'd0);
    assign fill_cnt   = cnt_q;
    assign overflow   = ovf_q;
    assign frag_err   = frag_q;

endmodule

// File: tb/tb_at_byte_collector.sv
// Self-checking bench for at_byte_collector: table-driven words plus hand sequences,
// with a scoreboard queue comparing every popped word in order.
module tb_at_byte_collector;
    logic         clk = 1'b0;
    logic         rst_n, in_valid, word_ready, err_clr;
    logic [7:0]   in_data;
    logic         word_valid, overflow, frag_err;
    logic [127:0] word_data;
    logic [1:0]   fill_cnt;

    int nchecks = 0;
    int nerr    = 0;
    logic [127:0] sb_q[$];

    typedef struct {
        logic [7:0]   base;
        int           gap;
        logic [127:0] exp;
    } vec_t;
    vec_t tbl[3];

    at_byte_collector #(.NUM_BYTES(16), .DATA_W(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .word_ready(word_ready), .err_clr(err_clr), .word_valid(word_valid),
        .word_data(word_data), .fill_cnt(fill_cnt), .overflow(overflow),
        .frag_err(frag_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [7:0] base);
        logic [127:0] w = '0;
        for (int i = 0; i < 16; i++) w = {w[119:0], 8'(base + 8'(i))};
        return w;
    endfunction

    task automatic step(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic send_word(input logic [7:0] base, input int gap, input bit chk_lat);
        for (int i = 0; i < 16; i++) begin
            if (chk_lat && i == 15) check("valid_before_last", 128'(word_valid), 128'(0));
            step(1'b1, 8'(base + 8'(i)));
            if (i < 15) idle(gap);
        end
        in_valid = 1'b0;
    endtask

    // Scoreboard: every handshake pops the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && word_valid && word_ready) begin
            if (sb_q.size() == 0) begin
                nchecks++;
                nerr++;
                $display("FAIL unexpected_word: got %h expected none", word_data);
            end else begin
                check("word_data", word_data, sb_q.pop_front());
            end
        end
    end

    initial begin
        tbl[0] = '{8'h00, 0,  128'h000102030405060708090A0B0C0D0E0F};
        tbl[1] = '{8'hA0, 3,  128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF};
        tbl[2] = '{8'h20, 63, 128'h202122232425262728292A2B2C2D2E2F};

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; word_ready = 1'b0; err_clr = 1'b0;
        idle(3);
        check("rst_word_valid", 128'(word_valid), 128'(0));
        check("rst_word_data",  word_data, 128'h0);
        check("rst_fill_cnt",   128'(fill_cnt), 128'(0));
        check("rst_overflow",   128'(overflow), 128'(0));
        check("rst_frag_err",   128'(frag_err), 128'(0));
        rst_n = 1'b1;
        word_ready = 1'b1;
        idle(1);

        // Table: back-to-back, gapped, and gap one short of the timeout.
        for (int k = 0; k < 3; k++) begin
            sb_q.push_back(tbl[k].exp);
            send_word(tbl[k].base, tbl[k].gap, 1'b1);
            check("valid_after_last", 128'(word_valid), 128'(1));
            idle(2);
            check("tbl_frag_err", 128'(frag_err), 128'(0));
            check("tbl_fill_cnt", 128'(fill_cnt), 128'(0));
        end

        // Partial word times out, then a full word follows.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + 8'(i)));
        idle(63);
        check("frag_before_timeout", 128'(frag_err), 128'(0));
        idle(1);
        check("frag_at_timeout", 128'(frag_err), 128'(1));
        sb_q.push_back(128'h101112131415161718191A1B1C1D1E1F);
        send_word(8'h10, 0, 1'b0);
        idle(2);
        check("frag_sticky", 128'(frag_err), 128'(1));
        err_clr = 1'b1; idle(1); err_clr = 1'b0;
        check("frag_cleared", 128'(frag_err), 128'(0));

        // Three words into a stalled FIFO: third one is dropped.
        word_ready = 1'b0;
        sb_q.push_back(mk(8'h30));
        sb_q.push_back(mk(8'h40));
        send_word(8'h30, 0, 1'b0);
        send_word(8'h40, 0, 1'b0);
        send_word(8'h60, 0, 1'b0);
        idle(2);
        check("ovf_fill_cnt", 128'(fill_cnt), 128'(2));
        check("ovf_flag",     128'(overflow), 128'(1));
        check("stall_data",   word_data, mk(8'h30));
        word_ready = 1'b1;
        idle(4);
        check("ovf_drained", 128'(fill_cnt), 128'(0));
        check("empty_hold",  word_data, mk(8'h40));
        err_clr = 1'b1; idle(1); err_clr = 1'b0;
        check("ovf_cleared", 128'(overflow), 128'(0));

        // Full FIFO with a pop in exactly the push cycle: nothing lost.
        word_ready = 1'b0;
        sb_q.push_back(mk(8'h70));
        sb_q.push_back(mk(8'h80));
        sb_q.push_back(mk(8'h90));
        send_word(8'h70, 0, 1'b0);
        send_word(8'h80, 0, 1'b0);
        idle(1);
        for (int i = 0; i < 15; i++) step(1'b1, 8'(8'h90 + 8'(i)));
        word_ready = 1'b1;
        step(1'b1, 8'h9F);
        word_ready = 1'b0;
        in_valid = 1'b0;
        check("simul_fill_cnt", 128'(fill_cnt), 128'(2));
        check("simul_overflow", 128'(overflow), 128'(0));
        idle(1);
        word_ready = 1'b1;
        idle(4);
        check("simul_drained", 128'(fill_cnt), 128'(0));

        // Reset mid-word discards the partial word silently.
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'hE0 + 8'(i)));
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        sb_q.push_back(128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
        send_word(8'hC0, 0, 1'b1);
        check("rst_mid_valid", 128'(word_valid), 128'(1));
        idle(2);
        check("rst_mid_ovf",  128'(overflow), 128'(0));
        check("rst_mid_frag", 128'(frag_err), 128'(0));
        check("rst_mid_fill", 128'(fill_cnt), 128'(0));

        idle(2);
        check("scoreboard_empty", 128'(sb_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
